// File: rtl/seg_canvas_editor.sv
// Click-to-edit 7-segment canvas: toggles segments under the mouse, decodes digits,
// flags a match against a target and renders an RGB565 pixel stream. Optional hints: SEG_CANVAS_HINT_EN.
module seg_canvas_editor #(
    parameter int NUM_DIGITS = 2,
    parameter int X0         = 4,
    parameter int Y0         = 4,
    parameter int PITCH      = 24,
    parameter int SEG_LEN    = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                x,
    input  logic [5:0]                y,
    input  logic [6:0]                x_cursor,
    input  logic [5:0]                y_cursor,
    input  logic                      click,
    input  logic                      clear,
    input  logic [4*NUM_DIGITS-1:0]   target,
    output logic [15:0]               oled_data,
    output logic [7*NUM_DIGITS-1:0]   seg_state,
    output logic [4*NUM_DIGITS-1:0]   digit_value,
    output logic                      match
);

    localparam int L   = SEG_LEN;
    localparam int BX1 = X0 + (NUM_DIGITS - 1) * PITCH + L;
    localparam int BY1 = Y0 + 2 * L;

    localparam logic [15:0] RED   = 16'hF800;
    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] GREEN = 16'h07E0;
    localparam logic [15:0] BLACK = 16'h0000;

    typedef enum logic {EDIT, MATCHED} state_t;
    typedef struct packed { int x0; int x1; int y0; int y1; } box_t;

    // Segment boxes relative to the digit origin; rectangles are inclusive.
    function automatic box_t seg_box(input int s);
        case (s)
            0:       seg_box = '{x0: 0,     x1: L, y0: 0,     y1: 2};
            1:       seg_box = '{x0: L - 2, x1: L, y0: 0,     y1: L};
            2:       seg_box = '{x0: L - 2, x1: L, y0: L,     y1: 2 * L};
            3:       seg_box = '{x0: 0,     x1: L, y0: 2 * L - 2, y1: 2 * L};
            4:       seg_box = '{x0: 0,     x1: 2, y0: L,     y1: 2 * L};
            5:       seg_box = '{x0: 0,     x1: 2, y0: 0,     y1: L};
            default: seg_box = '{x0: 0,     x1: L, y0: L - 1, y1: L + 1};
        endcase
    endfunction

    function automatic logic in_rect(input int px, input int py,
                                     input int x0, input int x1, input int y0, input int y1);
        return (px >= x0) && (px <= x1) && (py >= y0) && (py <= y1);
    endfunction

    function automatic logic in_seg(input int s, input int rx, input int ry, input int g);
        box_t b;
        b = seg_box(s);
        return in_rect(rx, ry, b.x0 - g, b.x1 + g, b.y0 - g, b.y1 + g);
    endfunction

    function automatic logic [3:0] decode(input logic [6:0] segs);
        case (segs)
            7'b0111111: decode = 4'd0;
            7'b0000110: decode = 4'd1;
            7'b1011011: decode = 4'd2;
            7'b1001111: decode = 4'd3;
            7'b1100110: decode = 4'd4;
            7'b1101101: decode = 4'd5;
            7'b1111101: decode = 4'd6;
            7'b0000111: decode = 4'd7;
            7'b1111111: decode = 4'd8;
            7'b1101111: decode = 4'd9;
            default:    decode = 4'hF;
        endcase
    endfunction

`ifdef SEG_CANVAS_HINT_EN
    localparam logic [15:0] GREY = 16'h8410;

    // Segments sharing an endpoint with segment s.
    function automatic logic [6:0] adj_mask(input int s);
        case (s)
            0:       adj_mask = 7'b0100010;
            1:       adj_mask = 7'b1000101;
            2:       adj_mask = 7'b1001010;
            3:       adj_mask = 7'b0010100;
            4:       adj_mask = 7'b1101000;
            5:       adj_mask = 7'b1010001;
            default: adj_mask = 7'b0110110;
        endcase
    endfunction

    function automatic logic in_corner(input int s, input int rx, input int ry);
        box_t b;
        b = seg_box(s);
        return in_rect(rx, ry, b.x0, b.x0 + 2, b.y0, b.y0 + 2) ||
               in_rect(rx, ry, b.x1 - 2, b.x1, b.y1 - 2, b.y1);
    endfunction
`endif

    logic [7*NUM_DIGITS-1:0] seg_q, seg_d, hit_mask;
    logic                    click_q;
    state_t                  state_q;
    logic                    match_q;
    logic [15:0]             oled_q, pixel_d;
    logic                    hit_found, click_edge, toggle, all_valid;

    assign click_edge = click & ~click_q;
    assign toggle     = click_edge & hit_found;

    always_comb begin
        all_valid = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            digit_value[4*d +: 4] = decode(seg_q[7*d +: 7]);
            if (digit_value[4*d +: 4] == 4'hF) all_valid = 1'b0;
        end
    end

    // NOTE: the first matching box in digit-then-segment order claims the click, so exactly one bit flips.
    always_comb begin
        hit_mask  = '0;
        hit_found = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            for (int s = 0; s < 7; s++) begin
                if (!hit_found && in_seg(s, int'(x_cursor) - X0 - d * PITCH, int'(y_cursor) - Y0, 0)) begin
                    hit_mask[7*d+s] = 1'b1;
                    hit_found       = 1'b1;
                end
            end
        end
    end

    always_comb begin
        seg_d = seg_q;
        if (clear)           seg_d = '0;
        else if (click_edge) seg_d = seg_q ^ hit_mask;
    end

    always_comb begin
        logic cursor_px, outline_px, lit_px, border_px;
`ifdef SEG_CANVAS_HINT_EN
        logic hint_px;
        hint_px = 1'b0;
`endif
        cursor_px  = in_rect(int'(x), int'(y), int'(x_cursor) - 1, int'(x_cursor) + 1,
                             int'(y_cursor) - 1, int'(y_cursor) + 1);
        border_px  = in_rect(int'(x), int'(y), X0 - 4, BX1 + 4, Y0 - 4, BY1 + 4) &&
                    !in_rect(int'(x), int'(y), X0 - 1, BX1 + 1, Y0 - 1, BY1 + 1);
        outline_px = 1'b0;
        lit_px     = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            for (int s = 0; s < 7; s++) begin
                if (in_seg(s, int'(x) - X0 - d * PITCH, int'(y) - Y0, 1) &&
                    !in_seg(s, int'(x) - X0 - d * PITCH, int'(y) - Y0, 0))
                    outline_px = 1'b1;
                if (seg_q[7*d+s] && in_seg(s, int'(x) - X0 - d * PITCH, int'(y) - Y0, 0))
                    lit_px = 1'b1;
`ifdef SEG_CANVAS_HINT_EN
                if (!seg_q[7*d+s] && |(adj_mask(s) & seg_q[7*d +: 7]) &&
                    in_corner(s, int'(x) - X0 - d * PITCH, int'(y) - Y0))
                    hint_px = 1'b1;
`endif
            end
        end
        if (cursor_px)       pixel_d = RED;
        else if (outline_px) pixel_d = WHITE;
        else if (lit_px)     pixel_d = WHITE;
`ifdef SEG_CANVAS_HINT_EN
        else if (hint_px)    pixel_d = GREY;
`endif
        else if (border_px)  pixel_d = GREEN;
        else                 pixel_d = BLACK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q   <= '0;
            click_q <= 1'b0;
            state_q <= EDIT;
            match_q <= 1'b0;
            oled_q  <= BLACK;
        end else begin
            seg_q   <= seg_d;
            click_q <= click;
            oled_q  <= pixel_d;
            case (state_q)
                EDIT: if (!toggle && !clear && all_valid && digit_value == target) begin
                    state_q <= MATCHED;
                    match_q <= 1'b1;
                end
                MATCHED: if (toggle || clear) begin
                    state_q <= EDIT;
                    match_q <= 1'b0;
                end
                default: begin
                    state_q <= EDIT;
                    match_q <= 1'b0;
                end
            endcase
        end
    end

    assign seg_state = seg_q;
    assign oled_data = oled_q;
    assign match     = match_q;

endmodule
